// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_REQ core LSUs and the host.
// The host wins by default but is throttled to HOST_BURST_MAX grants while any core waits.
module dmem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  input  logic                           host_valid,
  input  logic                           host_we,
  input  logic [ADDR_WIDTH-1:0]          host_addr,
  input  logic [DATA_WIDTH-1:0]          host_wdata,
  output logic                           host_ready,
  output logic                           host_rsp_valid,
  output logic [DATA_WIDTH-1:0]          host_rsp_rdata,
  output logic                           mem_WDME,
  output logic [ADDR_WIDTH-1:0]          mem_A,
  output logic [DATA_WIDTH-1:0]          mem_WD,
  input  logic [DATA_WIDTH-1:0]          mem_RD
);

  localparam int         PTR_W     = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_MAX = 8'(HOST_BURST_MAX);

  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]       host_cnt_reg, host_cnt_next;
  logic             any_core_valid, host_grant, core_grant, core_found;
  logic [PTR_W-1:0] core_sel;
  logic [PTR_W:0]   cand_sum;
  logic [PTR_W-1:0] cand;
  logic             host_rsp_valid_reg;
  logic [DATA_WIDTH-1:0] host_rsp_rdata_reg;

  assign any_core_valid = |req_valid;
  assign host_grant     = rst_n && host_valid && (!any_core_valid || host_cnt_reg < BURST_MAX);

  // First valid core at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    core_sel   = '0;
    core_found = 1'b0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ))
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (!core_found && req_valid[cand]) begin
        core_found = 1'b1;
        core_sel   = cand;
      end
    end
  end

  assign core_grant = rst_n && !host_grant && core_found;
  assign host_ready = host_grant;

  always_comb begin
    mem_WDME = 1'b0;
    mem_A    = '0;
    mem_WD   = '0;
    if (host_grant) begin
      mem_WDME = host_we;
      mem_A    = host_addr;
      mem_WD   = host_wdata;
    end else if (core_grant) begin
      mem_WDME = req_we[core_sel];
      mem_A    = req_addr[core_sel*ADDR_WIDTH +: ADDR_WIDTH];
      mem_WD   = req_wdata[core_sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    host_cnt_next = host_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    if (!any_core_valid || core_grant)
      host_cnt_next = 8'd0;
    else if (host_grant && host_cnt_reg < BURST_MAX)
      host_cnt_next = host_cnt_reg + 8'd1;
    if (core_grant)
      rr_ptr_next = (core_sel == PTR_W'(NUM_REQ-1)) ? '0 : core_sel + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg         <= '0;
      host_cnt_reg       <= 8'd0;
      host_rsp_valid_reg <= 1'b0;
      host_rsp_rdata_reg <= '0;
    end else begin
      rr_ptr_reg         <= rr_ptr_next;
      host_cnt_reg       <= host_cnt_next;
      host_rsp_valid_reg <= host_grant;
      if (host_grant)
        host_rsp_rdata_reg <= host_we ? '0 : mem_RD;
    end
  end

  assign host_rsp_valid = host_rsp_valid_reg;
  assign host_rsp_rdata = host_rsp_rdata_reg;

  // Per-core grant decode and response registers; read data holds until the next response.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_core
      logic                  grant_this;
      logic                  rsp_valid_reg;
      logic [DATA_WIDTH-1:0] rsp_rdata_reg;

      assign grant_this    = core_grant && (core_sel == PTR_W'(gi));
      assign req_ready[gi] = grant_this;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_reg <= 1'b0;
          rsp_rdata_reg <= '0;
        end else begin
          rsp_valid_reg <= grant_this;
          if (grant_this)
            rsp_rdata_reg <= req_we[gi] ? '0 : mem_RD;
        end
      end

      assign rsp_valid[gi]                           = rsp_valid_reg;
      assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH]  = rsp_rdata_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// all compared against a grant/memory reference model kept in the bench.
module tb_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0, rsp_rdata;
  logic            host_valid = 1'b0, host_we = 1'b0, host_ready, host_rsp_valid;
  logic [AW-1:0]   host_addr = '0, mem_A;
  logic [DW-1:0]   host_wdata = '0, host_rsp_rdata, mem_WD, mem_RD;
  logic            mem_WDME;

  dmem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_BURST_MAX(HB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
    .mem_WDME(mem_WDME), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  // Data memory environment: combinational read, write on the clock edge.
  logic [DW-1:0] env_mem [0:255] = '{default: '0};
  assign mem_RD = env_mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WDME) env_mem[mem_A[9:2]] <= mem_WD;

  // Reference model state
  logic [DW-1:0] m_mem [0:255] = '{default: '0};
  logic [DW-1:0] m_rdata [N];
  logic [DW-1:0] m_hrdata;
  logic [N-1:0]  m_rsp_v;
  logic          m_hrsp_v;
  int m_rr, m_cnt, last_w, checks_total, checks_passed, cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; m_hrdata = '0; m_rsp_v = '0; m_hrsp_v = 1'b0;
    for (int i = 0; i < N; i++) m_rdata[i] = '0;
  endtask

  // -1: no grant, N: host, else core index. Closest valid core in ring distance from m_rr.
  function automatic int pick();
    int best, bestd, d;
    if (!rst_n) return -1;
    if (host_valid && (req_valid == '0 || m_cnt < HB)) return N;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_rr + N) % N;
      if (req_valid[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  task automatic set_core(input int i, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_core(input int i);
    set_core(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 2, $urandom());
  endtask

  task automatic rand_host();
    host_valid = 1'b1;
    host_we    = 1'($urandom_range(0, 1));
    host_addr  = AW'($urandom_range(0, 15)) << 2;
    host_wdata = $urandom();
  endtask

  // One clock: check combinational grant/memory drive at negedge, responses just after posedge.
  task automatic cycle();
    int w;
    logic any, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    @(negedge clk);
    w = pick();
    any = |req_valid;
    a = '0; d = '0; we = 1'b0;
    if (w == N) begin
      a = host_addr; d = host_wdata; we = host_we;
    end else if (w >= 0) begin
      a = req_addr[w*AW +: AW]; d = req_wdata[w*DW +: DW]; we = req_we[w];
    end
    check("req_ready", 64'(req_ready), 64'((w >= 0 && w < N) ? (1 << w) : 0));
    check("host_ready", 64'(host_ready), 64'(w == N));
    check("mem_WDME", 64'(mem_WDME), 64'(we));
    check("mem_A", 64'(mem_A), 64'(a));
    check("mem_WD", 64'(mem_WD), 64'(d));
    m_rsp_v = '0; m_hrsp_v = 1'b0;
    if (w >= 0) begin
      rd = we ? '0 : m_mem[a[9:2]];
      if (we) m_mem[a[9:2]] = d;
      if (w == N) begin m_hrsp_v = 1'b1; m_hrdata = rd; end
      else begin m_rsp_v[w] = 1'b1; m_rdata[w] = rd; end
      $display("cyc %0d grant %s we=%0b addr=%h wdata=%h", cyc,
               (w == N) ? "host" : $sformatf("core%0d", w), we, a, d);
    end
    if (rst_n) begin
      if (!any || (w >= 0 && w < N)) m_cnt = 0;
      else if (w == N && m_cnt < HB) m_cnt++;
      if (w >= 0 && w < N) m_rr = (w + 1) % N;
    end
    last_w = w;
    cyc++;
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
    check("host_rsp_valid", 64'(host_rsp_valid), 64'(m_hrsp_v));
    check("host_rsp_rdata", 64'(host_rsp_rdata), 64'(m_hrdata));
    for (int i = 0; i < N; i++)
      check($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata[i*DW +: DW]), 64'(m_rdata[i]));
  endtask

  initial begin
    int hcount, w0;
    checks_total = 0; checks_passed = 0; cyc = 0; last_w = -1;
    model_reset();

    // Reset with every requester asserting valid
    req_valid = '1; host_valid = 1'b1;
    @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset host_ready", 64'(host_ready), 64'(0));
    check("reset mem_WDME", 64'(mem_WDME), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset host_rsp_valid", 64'(host_rsp_valid), 64'(0));
    check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
    @(posedge clk); #1;
    req_valid = '0; host_valid = 1'b0;
    rst_n = 1'b1;

    // Core 2 writes, then core 0 reads the same address
    set_core(2, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    cycle();
    set_core(2, 1'b0, 1'b0, '0, '0);
    set_core(0, 1'b1, 1'b0, 32'h100, '0);
    cycle();
    check("raw core0 rdata", 64'(rsp_rdata[0*DW +: DW]), 64'(32'hDEADBEEF));
    check("write core2 rdata", 64'(rsp_rdata[2*DW +: DW]), 64'(0));
    set_core(0, 1'b0, 1'b0, '0, '0);

    // All cores continuously valid: grants rotate one per cycle
    for (int i = 0; i < N; i++) rand_core(i);
    w0 = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 0) w0 = last_w;
      else check("rotation", 64'(last_w), 64'((w0 + k) % N));
      rand_core(last_w);
    end
    req_valid = '0;

    // Host streaming against core 1: HB host grants then one core grant
    rand_host(); rand_core(1);
    hcount = 0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (last_w == N) begin hcount++; rand_host(); end
      else rand_core(1);
    end
    check("host burst count", 64'(hcount), 64'(12));

    // Host alone is never throttled
    req_valid = '0;
    hcount = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_w == N) hcount++;
      rand_host();
    end
    check("host alone count", 64'(hcount), 64'(10));
    host_valid = 1'b0;

    // Reset right after a read grant loses the response
    set_core(3, 1'b1, 1'b0, 32'h100, '0);
    @(negedge clk);
    check("pre-reset ready", 64'(req_ready), 64'(4'b1000));
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset rsp_valid", 64'(rsp_valid), 64'(0));
    check("midreset rsp_rdata3", 64'(rsp_rdata[3*DW +: DW]), 64'(0));
    model_reset();
    set_core(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    check("in-reset ready", 64'(req_ready), 64'(0));
    check("in-reset mem_WDME", 64'(mem_WDME), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post-release rsp_valid", 64'(rsp_valid), 64'(0));
    cycle();
    check("post-release winner", 64'(last_w), 64'(1));

    // Random traffic; requesters hold their request until granted
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || last_w == i) begin
          if ($urandom_range(0, 1) == 1) rand_core(i);
          else set_core(i, 1'b0, 1'b0, '0, '0);
        end
      if (!host_valid || last_w == N) begin
        if ($urandom_range(0, 2) == 0) rand_host();
        else host_valid = 1'b0;
      end
      cycle();
    end

    req_valid = '0; host_valid = 1'b0;
    cycle();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single data-memory port (`data_mem` core-side `WDME`/`A`/`WD`/`RD`) between `NUM_REQ` compute-core load/store requesters and one host (AXI-side) requester. Issues at most one memory access per cycle, registers the read data back to the winning requester, and gives the host priority with a bounded burst length so cores cannot starve. Sits between the core LSUs / AXI slave and `data_mem`.

## Interface
- `NUM_REQ`, 4: number of core requesters (2..16).
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data word width.
- `HOST_BURST_MAX`, 4: maximum consecutive host grants while any core is waiting (1..255).

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  core i request valid.
- `req_we`  in  NUM_REQ  core i write (1) / read (0).
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  core i byte address, slice i.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  core i write data, slice i.
- `req_ready`  out  NUM_REQ  core i granted this cycle.
- `rsp_valid`  out  NUM_REQ  core i response pulse.
- `rsp_rdata`  out  NUM_REQ*DATA_WIDTH  core i read data, slice i.
- `host_valid`, `host_we`  in  1 each  host request / write.
- `host_addr`  in  ADDR_WIDTH; `host_wdata`  in  DATA_WIDTH.
- `host_ready`  out  1  host granted this cycle.
- `host_rsp_valid`  out  1; `host_rsp_rdata`  out  DATA_WIDTH.
- `mem_WDME`  out  1  write enable to data memory.
- `mem_A`  out  ADDR_WIDTH  address to data memory.
- `mem_WD`  out  DATA_WIDTH  write data to data memory.
- `mem_RD`  in  DATA_WIDTH  combinational read data from data memory.

## Operation
- Handshake: transfer occurs in a cycle where valid && ready. Requester holds valid, we, addr, wdata stable until ready. Ready is combinational from valid and arbiter state; at most one of {host_ready, req_ready[*]} high per cycle.
- Grant selection each cycle:
  - Host wins if host_valid and (no core valid or host_cnt < HOST_BURST_MAX).
  - Otherwise the first valid core found searching from rr_ptr upward, wrapping modulo NUM_REQ.
- host_cnt: increments on a host grant while any req_valid is high (saturates at HOST_BURST_MAX); clears on any core grant or any cycle with no core valid.
- rr_ptr: on core grant to index i, rr_ptr <= (i+1) mod NUM_REQ; unchanged otherwise.
- Memory drive: mem_A/mem_WD/mem_WDME = granted requester's addr/wdata/we; no grant -> mem_WDME=0, mem_A/mem_WD = 0.
- Response: on grant, response register for that requester captures mem_RD for reads, 0 for writes; *_rsp_valid pulses high the following cycle. rsp_rdata / host_rsp_rdata hold the last value until that requester's next response.
- Addresses pass through unmodified; word alignment and range wrap belong to data_mem.

## Timing
- Reset (rst_n low, async): rr_ptr=0, host_cnt=0, all rsp_valid=0, host_rsp_valid=0, all rsp_rdata/host_rsp_rdata=0. While rst_n low, all ready outputs and mem_WDME forced 0.
- Grant in cycle T: write commits at the T/T+1 edge; response valid in T+1 for exactly one cycle. Latency 1, throughput 1 access/cycle.
- Read-after-write from different requesters in T, T+1: read in T+1 returns data written in T.
- Back-to-back grants to the same requester produce back-to-back rsp_valid pulses.
- Reset deasserted mid-stream: in-flight responses are lost; no rsp_valid in the first cycle after release.
- Single core valid with no host: granted every cycle it is valid.

## Test plan
- Reset: hold rst_n=0 with all valids high -> all ready=0, mem_WDME=0, all rsp_valid=0, rsp_rdata=0.
- Core 2 writes 0xDEADBEEF to 0x100, then core 0 reads 0x100 -> core 0 rsp_valid in grant+1 with rsp_rdata=0xDEADBEEF; core 2 gets write rsp_valid with rdata 0.
- All 4 cores continuously valid, no host -> grants rotate 0,1,2,3,0,... one per cycle; each rsp_valid one cycle after its grant.
- Host continuously valid with core 1 valid, HOST_BURST_MAX=4 -> 4 host grants, 1 core-1 grant, repeat; host_cnt returns to 0 after core grant.
- Host valid alone for 10 cycles -> 10 consecutive host grants, no throttling.
- Assert rst_n=0 in the cycle after a read grant -> rsp_valid stays 0, rr_ptr=0, next grant after release goes to lowest valid core index.
